// File: rtl/alu_result_mux_n.sv
// N-way W-bit result selector with one registered output stage and valid/ready handshake.
// Define RESULT_MUX_PARITY_EN to add the registered out_parity output.
module alu_result_mux_n #(
  parameter int W = 32,
  parameter int N = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
`ifdef RESULT_MUX_PARITY_EN
  output logic             out_parity,
`endif
  output logic             sel_err
);

  localparam logic [SEL_W:0]   N_L  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);

  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] osel_q, osel_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] ch;
  logic             in_range;
  logic [W-1:0]     mux;
  logic             accept;

  assign in_ready = !reset && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign ch       = scan_mode ? ptr_q : sel;
  assign in_range = ({1'b0, ch} < N_L);

  // Out-of-range channels fall through to zero.
  always_comb begin
    mux = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SEL_W'(k)) mux = in_data[k*W +: W];
    end
  end

  always_comb begin
    data_d = data_q;
    osel_d = osel_q;
    vld_d  = vld_q;
    err_d  = err_q;
    ptr_d  = ptr_q;
    if (err_clr) err_d = 1'b0;
    if (accept) begin
      data_d = in_range ? mux : '0;
      osel_d = ch;
      vld_d  = 1'b1;
      if (!in_range) err_d = 1'b1;
      if (scan_mode) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      osel_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      osel_q <= osel_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign out_valid = vld_q;
  assign sel_err   = err_q;

`ifdef RESULT_MUX_PARITY_EN
  logic par_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else if (accept) par_q <= in_range ? ^mux : 1'b0;
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_alu_result_mux_n.sv
// Directed bench for alu_result_mux_n: an N=8 and an N=6 instance share stimulus
// and are checked every cycle against a behavioural model plus literal expectations.
module tb_alu_result_mux_n;

  logic         clock = 1'b0;
  logic         reset;
  logic [255:0] in_data;
  logic [2:0]   sel;
  logic         scan_mode, in_valid, out_ready, err_clr;

  logic [31:0] od8, od6;
  logic [2:0]  os8, os6;
  logic        ov8, ov6, rdy8, rdy6, er8, er6;
`ifdef RESULT_MUX_PARITY_EN
  logic        op8, op6;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_result_mux_n #(.W(32), .N(8)) u8 (
    .clock(clock), .reset(reset), .in_data(in_data), .sel(sel),
    .scan_mode(scan_mode), .in_valid(in_valid), .in_ready(rdy8),
    .out_data(od8), .out_sel(os8), .out_valid(ov8),
    .out_ready(out_ready), .err_clr(err_clr),
`ifdef RESULT_MUX_PARITY_EN
    .out_parity(op8),
`endif
    .sel_err(er8));

  alu_result_mux_n #(.W(32), .N(6)) u6 (
    .clock(clock), .reset(reset), .in_data(in_data[191:0]), .sel(sel),
    .scan_mode(scan_mode), .in_valid(in_valid), .in_ready(rdy6),
    .out_data(od6), .out_sel(os6), .out_valid(ov6),
    .out_ready(out_ready), .err_clr(err_clr),
`ifdef RESULT_MUX_PARITY_EN
    .out_parity(op6),
`endif
    .sel_err(er6));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, index 0 = N=8 instance, 1 = N=6 instance
  int          nch [2] = '{8, 6};
  logic        m_ov [2] = '{1'b0, 1'b0};
  logic [31:0] m_od [2] = '{32'd0, 32'd0};
  int          m_os [2] = '{0, 0};
  logic        m_er [2] = '{1'b0, 1'b0};
  int          m_pt [2] = '{0, 0};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_ov[i] <= 1'b0; m_od[i] <= '0; m_os[i] <= 0;
        m_er[i] <= 1'b0; m_pt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int c;
        bit acc;
        acc = in_valid && (!m_ov[i] || out_ready);
        c = scan_mode ? m_pt[i] : int'(sel);
        if (acc) begin
          m_ov[i] <= 1'b1;
          m_os[i] <= c;
          m_od[i] <= (c < nch[i]) ? in_data[c*32 +: 32] : 32'd0;
          if (c >= nch[i]) m_er[i] <= 1'b1;
          else if (err_clr) m_er[i] <= 1'b0;
          if (scan_mode) m_pt[i] <= (m_pt[i] + 1) % nch[i];
        end else begin
          if (out_ready) m_ov[i] <= 1'b0;
          if (err_clr) m_er[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("u8 out_valid", 64'(ov8), 64'(m_ov[0]));
    chk("u8 out_data", 64'(od8), 64'(m_od[0]));
    chk("u8 out_sel", 64'(os8), 64'(m_os[0]));
    chk("u8 sel_err", 64'(er8), 64'(m_er[0]));
    chk("u8 in_ready", 64'(rdy8), 64'(!reset && (!m_ov[0] || out_ready)));
    chk("u6 out_valid", 64'(ov6), 64'(m_ov[1]));
    chk("u6 out_data", 64'(od6), 64'(m_od[1]));
    chk("u6 out_sel", 64'(os6), 64'(m_os[1]));
    chk("u6 sel_err", 64'(er6), 64'(m_er[1]));
    chk("u6 in_ready", 64'(rdy6), 64'(!reset && (!m_ov[1] || out_ready)));
`ifdef RESULT_MUX_PARITY_EN
    chk("u8 parity", 64'(op8), 64'(^m_od[0]));
    chk("u6 parity", 64'(op6), 64'(^m_od[1]));
`endif
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sel = '0; scan_mode = 0; in_valid = 0; out_ready = 0; err_clr = 0;
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = 32'h1000 + k;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst out_valid", 64'(ov8), 64'd0);
    chk("rst out_data", 64'(od8), 64'd0);
    chk("rst sel_err", 64'(er6), 64'd0);
    chk("rst in_ready", 64'(rdy8), 64'd1);

    // direct select of channel 5
    sel = 3'd5; in_valid = 1; out_ready = 1;
    cyc();
    chk("t2 data", 64'(od8), 64'h1005);
    chk("t2 sel", 64'(os8), 64'd5);
    chk("t2 valid", 64'(ov8), 64'd1);

    // stall for 3 cycles
    out_ready = 0; sel = 3'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3 stall ready", 64'(rdy8), 64'd0);
      chk("t3 stall data", 64'(od8), 64'h1005);
    end
    out_ready = 1;
    cyc();
    chk("t3 resume a", 64'(od8), 64'h1002);
    sel = 3'd3;
    cyc();
    chk("t3 resume b", 64'(od8), 64'h1003);
    sel = 3'd6;
    cyc();
    chk("t3 resume c", 64'(od8), 64'h1006);

    // round-robin scan
    scan_mode = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4 scan sel", 64'(os8), 64'(i % 8));
      chk("t4 scan data", 64'(od8), 64'(32'h1000 + i % 8));
    end
    scan_mode = 0; sel = 3'd4;
    cyc(); cyc();
    scan_mode = 1;
    cyc();
    chk("t4 ptr kept", 64'(os8), 64'd2);
    chk("t4 ptr kept n6", 64'(os6), 64'd4);

    // out-of-range select on the 6-channel instance
    scan_mode = 0; sel = 3'd7;
    cyc();
    chk("t5 oor data", 64'(od6), 64'd0);
    chk("t5 oor sel", 64'(os6), 64'd7);
    chk("t5 oor err", 64'(er6), 64'd1);
    chk("t5 n8 data", 64'(od8), 64'h1007);
    chk("t5 n8 err", 64'(er8), 64'd0);
    err_clr = 1;
    cyc();
    chk("t5 clr vs set", 64'(er6), 64'd1);
    in_valid = 0;
    cyc();
    chk("t5 clr alone", 64'(er6), 64'd0);
    err_clr = 0;

    // asynchronous reset with a valid output pending
    in_valid = 1; sel = 3'd7;
    cyc();
    chk("t1 pre err", 64'(er6), 64'd1);
    reset = 1'b1;
    #1;
    chk("t1 valid", 64'(ov6), 64'd0);
    chk("t1 data", 64'(od8), 64'd0);
    chk("t1 err", 64'(er6), 64'd0);
    chk("t1 ready", 64'(rdy8), 64'd0);
    cyc();
    chk("t1 ready held", 64'(rdy6), 64'd0);
    reset = 1'b0; sel = 3'd1;
    cyc();
    chk("t1 after", 64'(od8), 64'h1001);

`ifdef RESULT_MUX_PARITY_EN
    in_data[3*32 +: 32] = 32'h0000_0007;
    in_data[4*32 +: 32] = 32'h0000_0003;
    sel = 3'd3;
    cyc();
    chk("t6 parity odd", 64'(op8), 64'd1);
    sel = 3'd4;
    cyc();
    chk("t6 parity even", 64'(op8), 64'd0);
`endif

    in_valid = 0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
